// File: rtl/anc_pipeline_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// anc_pipeline_sequencer
//
// Per-sample scheduler for the noise-cancel datapath. Each audio sample
// runs a frame of four stages in order: lowpass -> error calculator ->
// NLMS weight update -> FIR output. When adaptation is disabled, the NLMS
// stage is skipped. Each stage is started with a one-cycle start pulse. The
// sequencer then waits for that stage's done pulse before it moves on.
//
// A sample that arrives while a frame is running is held in a one-deep
// backlog. A further sample in the same frame is dropped and counted as an
// overrun. A per-stage watchdog aborts a frame whose stage never answers.
// The cycle count from the lowpass start to the FIR done is reported for
// every frame that completes.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-low reset
//   sample_valid_in       one-cycle strobe: new audio sample available
//   adapt_en_in           1 = run the NLMS stage, 0 = skip it
//   clear_in              clears the sticky flags and the overrun counter
//   *_done_in             done pulses from lowpass / error / NLMS / FIR
//   *_start_out           one-cycle start pulses to the same four stages
//   busy_out              a frame is in flight
//   frame_done_out        one-cycle pulse when a frame completes normally
//   overrun_out           sticky: a sample was dropped
//   overrun_count_out     dropped-sample count, saturating
//   timeout_out           sticky: a stage exceeded TIMEOUT_CYCLES
//   fault_stage_out       stage of the last timeout (0 LP,1 ERR,2 LMS,3 FIR)
//   latency_out           lowpass start to FIR done, last completed frame
// All outputs are registered.
// ---------------------------------------------------------------------------
module anc_pipeline_sequencer #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int CNT_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sample_valid_in,
    input  logic             adapt_en_in,
    input  logic             clear_in,
    input  logic             lowpass_done_in,
    input  logic             error_done_in,
    input  logic             lms_done_in,
    input  logic             fir_done_in,
    output logic             lowpass_start_out,
    output logic             error_start_out,
    output logic             lms_start_out,
    output logic             fir_start_out,
    output logic             busy_out,
    output logic             frame_done_out,
    output logic             overrun_out,
    output logic [CNT_W-1:0] overrun_count_out,
    output logic             timeout_out,
    output logic [1:0]       fault_stage_out,
    output logic [15:0]      latency_out
);

    // The watchdog is 0 in a stage's start-pulse cycle. The frame is aborted
    // in the cycle where it reads TIMEOUT_CYCLES-1, which gives each stage
    // exactly TIMEOUT_CYCLES cycles, start cycle included. The extra bit
    // covers the single increment that happens on the abort cycle itself.
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LP,
        S_ERR,
        S_LMS,
        S_FIR
    } state_t;

    state_t          state, state_next;
    logic            pending, pending_next;
    logic [WD_W-1:0] wdog;
    logic [15:0]     lat_cnt;

    logic [3:0] start_next;     // {fir, lms, err, lp}
    logic       frame_done_next;
    logic       lat_load;
    logic       stage_done;
    logic [1:0] stage_code;
    logic       timeout_hit;
    logic [1:0] fault_next;
    logic       sample_busy;
    logic       overrun_evt;

    // -----------------------------------------------------------------------
    // Next-state and pulse decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // a path that skips an assignment cannot infer a latch.
        state_next      = state;
        pending_next    = pending;
        start_next      = 4'b0000;
        frame_done_next = 1'b0;
        lat_load        = 1'b0;
        stage_done      = 1'b0;
        stage_code      = 2'd0;
        timeout_hit     = 1'b0;
        fault_next      = fault_stage_out;

        case (state)
            S_IDLE: begin
                if (sample_valid_in) begin
                    state_next = S_LP;
                    start_next = 4'b0001;
                end
            end
            S_LP: begin
                stage_code = 2'd0;
                stage_done = lowpass_done_in;
                if (lowpass_done_in) begin
                    state_next = S_ERR;
                    start_next = 4'b0010;
                end
            end
            S_ERR: begin
                stage_code = 2'd1;
                stage_done = error_done_in;
                if (error_done_in) begin
                    if (adapt_en_in) begin
                        state_next = S_LMS;
                        start_next = 4'b0100;
                    end else begin
                        state_next = S_FIR;
                        start_next = 4'b1000;
                    end
                end
            end
            S_LMS: begin
                stage_code = 2'd2;
                stage_done = lms_done_in;
                if (lms_done_in) begin
                    state_next = S_FIR;
                    start_next = 4'b1000;
                end
            end
            S_FIR: begin
                stage_code = 2'd3;
                stage_done = fir_done_in;
                if (fir_done_in) begin
                    frame_done_next = 1'b1;
                    lat_load        = 1'b1;
                    pending_next    = 1'b0;
                    // A backlogged sample, or one arriving right now,
                    // starts the next frame back-to-back.
                    if (pending || sample_valid_in) begin
                        state_next = S_LP;
                        start_next = 4'b0001;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Samples that land mid-frame go to the backlog. The FIR-done cycle
        // is excluded because there the sample directly restarts the frame.
        sample_busy = sample_valid_in && (state != S_IDLE)
                      && !((state == S_FIR) && fir_done_in);
        overrun_evt = sample_busy && pending;
        if (sample_busy && !pending) begin
            pending_next = 1'b1;
        end

        // Watchdog abort. A done pulse in the limit cycle takes precedence.
        if ((state != S_IDLE) && !stage_done && (wdog == WD_LIMIT)) begin
            timeout_hit  = 1'b1;
            fault_next   = stage_code;
            state_next   = S_IDLE;
            start_next   = 4'b0000;
            pending_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= S_IDLE;
            pending           <= 1'b0;
            wdog              <= '0;
            lat_cnt           <= 16'd0;
            lowpass_start_out <= 1'b0;
            error_start_out   <= 1'b0;
            lms_start_out     <= 1'b0;
            fir_start_out     <= 1'b0;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
            overrun_out       <= 1'b0;
            overrun_count_out <= '0;
            timeout_out       <= 1'b0;
            fault_stage_out   <= 2'd0;
            latency_out       <= 16'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // right-hand side in this block sees the pre-edge values.
            state   <= state_next;
            pending <= pending_next;
            {fir_start_out, lms_start_out, error_start_out, lowpass_start_out} <= start_next;
            busy_out       <= (state_next != S_IDLE);
            frame_done_out <= frame_done_next;

            if (|start_next) begin
                wdog <= '0;
            end else if (state != S_IDLE) begin
                wdog <= wdog + WD_W'(1);
            end

            if (start_next[0]) begin
                lat_cnt <= 16'd0;
            end else if ((state != S_IDLE) && (lat_cnt != 16'hFFFF)) begin
                lat_cnt <= lat_cnt + 16'd1;
            end

            if (lat_load) begin
                latency_out <= lat_cnt;
            end

            // A new overrun beats a simultaneous clear.
            if (overrun_evt) begin
                overrun_out <= 1'b1;
                if (clear_in) begin
                    overrun_count_out <= CNT_W'(1);
                end else if (overrun_count_out != {CNT_W{1'b1}}) begin
                    overrun_count_out <= overrun_count_out + CNT_W'(1);
                end
            end else if (clear_in) begin
                overrun_out       <= 1'b0;
                overrun_count_out <= '0;
            end

            if (timeout_hit) begin
                timeout_out <= 1'b1;
            end else if (clear_in) begin
                timeout_out <= 1'b0;
            end
            fault_stage_out <= fault_next;
        end
    end

endmodule

// File: tb/tb_anc_pipeline_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_anc_pipeline_sequencer
//
// Self-checking bench for anc_pipeline_sequencer. It has three parts:
//   - stimulus tables for the nominal and bypass frames, checked cycle by
//     cycle,
//   - hand-written sequences for the backlog/overrun, timeout, stray done,
//     done-at-limit and mid-frame reset corner cases,
//   - a randomized run that compares every output, every cycle, against a
//     frame-level reference model.
// Inputs are driven 1 ns after the rising edge. Outputs are read at the same
// point, so each read observes the registered result of the previous cycle.
// ---------------------------------------------------------------------------
module tb_anc_pipeline_sequencer;

    localparam int TIMEOUT = 2048;
    localparam int CW      = 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          sample_valid_in = 1'b0;
    logic          adapt_en_in = 1'b0;
    logic          clear_in = 1'b0;
    logic          lowpass_done_in = 1'b0;
    logic          error_done_in = 1'b0;
    logic          lms_done_in = 1'b0;
    logic          fir_done_in = 1'b0;
    logic          lowpass_start_out, error_start_out, lms_start_out, fir_start_out;
    logic          busy_out, frame_done_out, overrun_out, timeout_out;
    logic [CW-1:0] overrun_count_out;
    logic [1:0]    fault_stage_out;
    logic [15:0]   latency_out;

    anc_pipeline_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .sample_valid_in   (sample_valid_in),
        .adapt_en_in       (adapt_en_in),
        .clear_in          (clear_in),
        .lowpass_done_in   (lowpass_done_in),
        .error_done_in     (error_done_in),
        .lms_done_in       (lms_done_in),
        .fir_done_in       (fir_done_in),
        .lowpass_start_out (lowpass_start_out),
        .error_start_out   (error_start_out),
        .lms_start_out     (lms_start_out),
        .fir_start_out     (fir_start_out),
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out),
        .overrun_out       (overrun_out),
        .overrun_count_out (overrun_count_out),
        .timeout_out       (timeout_out),
        .fault_stage_out   (fault_stage_out),
        .latency_out       (latency_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       sv;
        logic       adapt;
        logic [3:0] done;       // {fir, lms, err, lp}
        logic [3:0] exp_start;  // {fir, lms, err, lp}
        logic       exp_busy;
        logic       exp_fd;
    } vec_t;

    vec_t nom_tbl[$];
    vec_t byp_tbl[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic sv, input logic ad, input logic clr, input logic [3:0] dn);
        sample_valid_in = sv;
        adapt_en_in     = ad;
        clear_in        = clr;
        {fir_done_in, lms_done_in, error_done_in, lowpass_done_in} = dn;
    endtask

    function automatic logic [3:0] starts();
        return {fir_start_out, lms_start_out, error_start_out, lowpass_start_out};
    endfunction

    function automatic logic [63:0] pack(input logic [3:0] st, input logic b, input logic fd,
                                         input logic ov, input logic [7:0] cnt, input logic to,
                                         input logic [1:0] fs, input logic [15:0] lat);
        return {30'd0, st, b, fd, ov, cnt, to, fs, lat};
    endfunction

    function automatic logic [63:0] dut_pack();
        return pack(starts(), busy_out, frame_done_out, overrun_out, overrun_count_out,
                    timeout_out, fault_stage_out, latency_out);
    endfunction

    function automatic vec_t blank(input logic ad);
        vec_t v;
        v.sv = 1'b0; v.adapt = ad; v.done = 4'b0000;
        v.exp_start = 4'b0000; v.exp_busy = 1'b0; v.exp_fd = 1'b0;
        return v;
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            tick();
            check($sformatf("%s c%0d start", tag, i), 64'(starts()), 64'(tbl[i].exp_start));
            check($sformatf("%s c%0d busy", tag, i), 64'(busy_out), 64'(tbl[i].exp_busy));
            check($sformatf("%s c%0d frame_done", tag, i), 64'(frame_done_out), 64'(tbl[i].exp_fd));
            drive(tbl[i].sv, tbl[i].adapt, 1'b0, tbl[i].done);
        end
    endtask

    // ---------------- reference model (frame level, integer bookkeeping) ---
    // m_cur: stage index 0=LP 1=ERR 2=LMS 3=FIR, -1 = no frame in flight.
    // m_age: cycles since the current stage's start pulse.
    // m_lat: cycles since the frame's lowpass start pulse.
    int         m_cur, m_age, m_lat, m_backlog, m_cnt, m_latency, m_fault;
    logic       m_ov, m_to, m_busy, m_fd;
    logic [3:0] m_start;

    task automatic model_reset();
        m_cur = -1; m_age = 0; m_lat = 0; m_backlog = 0; m_cnt = 0;
        m_latency = 0; m_fault = 0; m_ov = 0; m_to = 0; m_busy = 0;
        m_fd = 0; m_start = 4'b0000;
    endtask

    // Advance the model by one cycle for the given inputs. The m_* outputs
    // then hold what the DUT must show in the following cycle.
    task automatic model_step(input logic sv, input logic ad, input logic clr, input logic [3:0] dn);
        logic ovr_evt;
        logic to_evt;
        logic fin;
        ovr_evt = 1'b0;
        to_evt  = 1'b0;
        m_start = 4'b0000;
        m_fd    = 1'b0;
        if (m_cur < 0) begin
            if (sv) begin
                m_cur = 0; m_age = 0; m_lat = 0; m_start = 4'b0001;
            end
        end else begin
            fin = dn[m_cur];
            if (sv && !(m_cur == 3 && fin)) begin
                if (m_backlog != 0) ovr_evt = 1'b1;
                else m_backlog = 1;
            end
            if (fin && m_cur == 3) m_latency = m_lat;
            if (m_lat < 65535) m_lat++;
            if (fin) begin
                if (m_cur == 3) begin
                    m_fd = 1'b1;
                    if (m_backlog != 0 || sv) begin
                        m_cur = 0; m_age = 0; m_lat = 0; m_start = 4'b0001;
                    end else begin
                        m_cur = -1;
                    end
                    m_backlog = 0;
                end else begin
                    m_cur   = (m_cur == 1 && !ad) ? 3 : m_cur + 1;
                    m_age   = 0;
                    m_start = 4'(1 << m_cur);
                end
            end else if (m_age == TIMEOUT - 1) begin
                to_evt = 1'b1; m_fault = m_cur; m_cur = -1; m_backlog = 0;
            end else begin
                m_age++;
            end
        end
        if (ovr_evt) begin
            m_ov = 1'b1;
            if (clr) m_cnt = 1;
            else if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else if (clr) begin
            m_ov = 1'b0; m_cnt = 0;
        end
        if (to_evt) m_to = 1'b1;
        else if (clr) m_to = 1'b0;
        m_busy = (m_cur >= 0);
    endtask

    initial begin
        logic       fir_seen, fd_seen, sv, ad, clr;
        logic [3:0] dn, st;
        int         due[4];

        // ---- stimulus tables ----
        // Nominal frame: each done arrives 3 cycles after its start.
        for (int i = 0; i < 19; i++) nom_tbl.push_back(blank(1'b1));
        nom_tbl[0].sv = 1'b1;
        nom_tbl[4].done  = 4'b0001; nom_tbl[8].done  = 4'b0010;
        nom_tbl[12].done = 4'b0100; nom_tbl[16].done = 4'b1000;
        nom_tbl[1].exp_start  = 4'b0001; nom_tbl[5].exp_start  = 4'b0010;
        nom_tbl[9].exp_start  = 4'b0100; nom_tbl[13].exp_start = 4'b1000;
        for (int i = 1; i <= 16; i++) nom_tbl[i].exp_busy = 1'b1;
        nom_tbl[17].exp_fd = 1'b1;
        // Bypass frame: NLMS skipped, FIR starts straight after ERR.
        for (int i = 0; i < 15; i++) byp_tbl.push_back(blank(1'b0));
        byp_tbl[0].sv = 1'b1;
        byp_tbl[4].done = 4'b0001; byp_tbl[8].done = 4'b0010; byp_tbl[12].done = 4'b1000;
        byp_tbl[1].exp_start = 4'b0001; byp_tbl[5].exp_start = 4'b0010;
        byp_tbl[9].exp_start = 4'b1000;
        for (int i = 1; i <= 12; i++) byp_tbl[i].exp_busy = 1'b1;
        byp_tbl[13].exp_fd = 1'b1;

        // ---- reset state ----
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        tick(); tick();
        check("reset outputs", dut_pack(), 64'd0);
        rst_in = 1'b1;
        tick(); tick();
        check("idle after release", dut_pack(), 64'd0);

        // ---- nominal and bypass frames ----
        tbl = nom_tbl;
        run_table("nominal");
        tick();
        check("nominal latency", 64'(latency_out), 64'd15);
        tbl = byp_tbl;
        run_table("bypass");
        tick();
        check("bypass latency", 64'(latency_out), 64'd11);

        // ---- backlog and overrun ----
        for (int c = 0; c <= 36; c++) begin
            tick();
            if (c == 3) check("backlog no extra start", 64'(starts()), 64'd0);
            if (c == 7) begin
                check("overrun flag", 64'(overrun_out), 64'd1);
                check("overrun count", 64'(overrun_count_out), 64'd1);
            end
            if (c == 17) begin
                check("backlog restart start", 64'(starts()), 64'b0001);
                check("backlog frame_done", 64'(frame_done_out), 64'd1);
            end
            if (c == 18) check("overrun held before clear", 64'(overrun_out), 64'd1);
            if (c == 19) begin
                check("overrun cleared", 64'(overrun_out), 64'd0);
                check("overrun count cleared", 64'(overrun_count_out), 64'd0);
            end
            if (c == 33) begin
                check("backlog 2nd frame_done", 64'(frame_done_out), 64'd1);
                check("backlog 2nd busy", 64'(busy_out), 64'd0);
            end
            if (c == 34) begin
                check("backlog 2nd latency", 64'(latency_out), 64'd15);
                check("backlog no 3rd frame", 64'(starts()), 64'd0);
            end
            dn = (c == 4 || c == 20) ? 4'b0001 : (c == 8 || c == 24) ? 4'b0010 :
                 (c == 12 || c == 28) ? 4'b0100 : (c == 16 || c == 32) ? 4'b1000 : 4'b0000;
            drive(c == 0 || c == 2 || c == 6, 1'b1, c == 18, dn);
        end

        // ---- timeout in the NLMS stage ----
        fir_seen = 1'b0;
        fd_seen  = 1'b0;
        for (int c = 0; c <= 2080; c++) begin
            tick();
            if (c >= 10 && c <= 2060) begin
                fir_seen = fir_seen | fir_start_out;
                fd_seen  = fd_seen | frame_done_out;
            end
            if (c == 9) check("timeout lms start", 64'(starts()), 64'b0100);
            if (c == 2056) begin
                check("timeout busy before limit", 64'(busy_out), 64'd1);
                check("timeout flag before limit", 64'(timeout_out), 64'd0);
            end
            if (c == 2057) begin
                check("timeout flag", 64'(timeout_out), 64'd1);
                check("timeout fault stage", 64'(fault_stage_out), 64'd2);
                check("timeout busy", 64'(busy_out), 64'd0);
                check("timeout latency kept", 64'(latency_out), 64'd15);
            end
            if (c == 2061) check("post-timeout lp start", 64'(starts()), 64'b0001);
            if (c == 2073) begin
                check("post-timeout frame_done", 64'(frame_done_out), 64'd1);
                check("post-timeout latency", 64'(latency_out), 64'd11);
                check("timeout sticky", 64'(timeout_out), 64'd1);
            end
            if (c == 2077) begin
                check("timeout cleared", 64'(timeout_out), 64'd0);
                check("fault stage kept", 64'(fault_stage_out), 64'd2);
            end
            dn = (c == 4 || c == 2064) ? 4'b0001 : (c == 8 || c == 2068) ? 4'b0010 :
                 (c == 2072) ? 4'b1000 : 4'b0000;
            drive(c == 0 || c == 2060, c < 2000, c == 2076, dn);
        end
        check("timeout no fir start", 64'(fir_seen), 64'd0);
        check("timeout no frame_done", 64'(fd_seen), 64'd0);

        // ---- stray done pulses, and a done in the watchdog-limit cycle ----
        for (int c = 0; c <= 2058; c++) begin
            tick();
            if (c == 3 || c == 4) begin
                check($sformatf("stray c%0d start", c), 64'(starts()), 64'd0);
                check($sformatf("stray c%0d busy", c), 64'(busy_out), 64'd1);
                check($sformatf("stray c%0d frame_done", c), 64'(frame_done_out), 64'd0);
            end
            if (c == 2049) begin
                check("limit-done err start", 64'(starts()), 64'b0010);
                check("limit-done no timeout", 64'(timeout_out), 64'd0);
            end
            if (c == 2053) check("limit-done fir start", 64'(starts()), 64'b1000);
            if (c == 2057) begin
                check("limit-done frame_done", 64'(frame_done_out), 64'd1);
                check("limit-done latency", 64'(latency_out), 64'd2055);
                check("limit-done timeout still 0", 64'(timeout_out), 64'd0);
            end
            dn = (c == 2 || c == 2056) ? 4'b1000 : (c == 3) ? 4'b0100 :
                 (c == 2048) ? 4'b0001 : (c == 2052) ? 4'b0010 : 4'b0000;
            drive(c == 0, 1'b0, 1'b0, dn);
        end

        // ---- reset asserted in the ERR stage ----
        tick(); drive(1'b1, 1'b1, 1'b0, 4'b0000);
        repeat (3) begin tick(); drive(1'b0, 1'b1, 1'b0, 4'b0000); end
        tick(); drive(1'b0, 1'b1, 1'b0, 4'b0001);
        tick();
        check("reset-test err start", 64'(starts()), 64'b0010);
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        check("reset-test busy before reset", 64'(busy_out), 64'd1);
        #2 rst_in = 1'b0;
        #1;
        check("mid-frame reset outputs", dut_pack(), 64'd0);
        tick(); tick();
        rst_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post-reset idle %0d", i), dut_pack(), 64'd0);
            drive(1'b0, 1'b1, 1'b0, (i == 4) ? 4'b0010 : 4'b0000);
        end
        tick(); drive(1'b1, 1'b1, 1'b0, 4'b0000);
        tick(); drive(1'b0, 1'b1, 1'b0, 4'b0000);
        check("post-reset lp start", 64'(starts()), 64'b0001);

        // ---- randomized run against the reference model ----
        #2 rst_in = 1'b0;
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        rst_in = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) due[i] = -1;
        for (int n = 0; n < 2000; n++) begin
            tick();
            check($sformatf("random c%0d", n), dut_pack(),
                  pack(m_start, m_busy, m_fd, m_ov, m_cnt[7:0], m_to, m_fault[1:0], m_latency[15:0]));
            st = starts();
            dn = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (st[i]) due[i] = n + int'($urandom_range(0, 6));
                if (due[i] == n) begin
                    dn[i]  = 1'b1;
                    due[i] = -1;
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                int k;
                k = int'($urandom_range(0, 3));
                dn[k] = 1'b1;
            end
            sv  = ($urandom_range(0, 9) == 0);
            ad  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 24) == 0);
            model_step(sv, ad, clr, dn);
            drive(sv, ad, clr, dn);
        end
        drive(1'b0, 1'b0, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/anc_pipeline_sequencer.md
Name: anc_pipeline_sequencer

Overview:
- Per-sample scheduler for the noise-cancel datapath. It starts each stage in order: lowpass, error calculator, NLMS weight update, FIR output.
- Each stage is started with a one-cycle start pulse. The sequencer then waits for that stage's done pulse before starting the next stage.
- Replaces the current done-to-ready daisy-chain. Adds an adaptation bypass, a one-deep sample backlog, overrun and timeout detection, and per-sample latency measurement.
- Sits between the audio sample strobe and the lowpass, error_calculator, NLMS and fir63 instances in the top level.

Parameters:
- TIMEOUT_CYCLES, 2048: maximum cycles allowed per stage, counted from its start pulse, before the frame is aborted.
- CNT_W, 8: width of the saturating overrun counter.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- sample_valid_in  in  1  one-cycle strobe: a new audio sample is available.
- adapt_en_in  in  1  1 = run the NLMS update; 0 = skip the NLMS stage (coefficients frozen).
- clear_in  in  1  one-cycle pulse: clears the sticky flags and the overrun counter.
- lowpass_done_in  in  1  lowpass stage done pulse.
- error_done_in  in  1  error stage done pulse.
- lms_done_in  in  1  NLMS stage done pulse.
- fir_done_in  in  1  FIR stage done pulse.
- lowpass_start_out  out  1  start pulse to lowpass (its ready_in).
- error_start_out  out  1  start pulse to error calculator (error_ready).
- lms_start_out  out  1  start pulse to NLMS (ready_in).
- fir_start_out  out  1  start pulse to FIR (ready_in).
- busy_out  out  1  high whenever the state is not IDLE.
- frame_done_out  out  1  one-cycle pulse when a frame completes normally.
- overrun_out  out  1  sticky: a sample was dropped.
- overrun_count_out  out  CNT_W  number of dropped samples, saturating.
- timeout_out  out  1  sticky: a stage exceeded TIMEOUT_CYCLES.
- fault_stage_out  out  2  stage that timed out: 0 = LP, 1 = ERR, 2 = LMS, 3 = FIR. Holds the value of the last fault.
- latency_out  out  16  cycles from the lowpass start pulse to the FIR done cycle for the last completed frame; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs are registered. While rst_in = 0, every output is 0, the state is IDLE, and the pending flag, watchdog and latency counter are 0.
- States: IDLE, LP, ERR, LMS, FIR.
- IDLE: sample_valid_in at cycle T → state LP, lowpass_start_out = 1 at cycle T+1 only.
- Stage transitions: in a stage, that stage's done pulse at cycle D → next stage, whose start pulse is high at cycle D+1 only.
  - LP → ERR.
  - ERR → LMS if adapt_en_in = 1, else ERR → FIR. adapt_en_in is sampled in the cycle error_done_in is seen.
  - LMS → FIR.
- FIR done:
  - Latch latency_out and pulse frame_done_out at D+1.
  - If the pending flag is set, or sample_valid_in = 1 in the same cycle D: go to LP, lowpass_start_out at D+1, clear pending.
  - Otherwise go to IDLE.
- Done inputs that do not belong to the current state are ignored, with no side effects.
- Backlog: sample_valid_in while busy (not in the FIR-done cycle) with pending = 0 → set pending.
  - With pending = 1 already → drop the sample, set overrun_out, increment overrun_count_out (saturates at all-ones).
- Watchdog:
  - Reset to 0 on each start pulse; increments every cycle while in a stage.
  - If it reaches TIMEOUT_CYCLES with no done pulse: set timeout_out, set fault_stage_out, clear pending, go to IDLE.
  - No start pulse is issued, no frame_done_out, and latency_out is unchanged.
  - If done arrives in the same cycle the limit is hit, done wins.
- Latency counter: 0 in the lowpass_start_out cycle, +1 per cycle after that, saturating. The value at the FIR done cycle is loaded into latency_out.
- clear_in: clears overrun_out, overrun_count_out and timeout_out the next cycle. If clear_in coincides with a new overrun, the overrun wins and the count becomes 1. fault_stage_out is not cleared.
- At most one start output is high in any cycle.
- Reset asserted mid-frame: outputs drop to 0 immediately and the in-flight frame is abandoned. After rst_in returns to 1, the sequencer waits in IDLE for the next sample_valid_in.

Test Plan:
- Nominal frame: adapt_en_in = 1, pulse sample_valid_in at cycle 0, and each stage returns done 3 cycles after its start.
  - Start pulses at cycles 1, 5, 9, 13; FIR done at 16.
  - frame_done_out at 17, latency_out = 15, then IDLE.
- Bypass: same stimulus with adapt_en_in = 0.
  - lms_start_out never pulses; fir_start_out at 9; latency_out = 11.
- Backlog and overrun: three sample_valid_in pulses during one frame.
  - Second pulse → pending; lowpass_start_out in the cycle after FIR done.
  - Third pulse → overrun_out = 1, overrun_count_out = 1.
  - clear_in then clears both.
- Timeout: withhold lms_done_in with TIMEOUT_CYCLES = 2048.
  - 2048 cycles after lms_start_out: timeout_out = 1, fault_stage_out = 2, busy_out = 0, no fir_start_out.
  - The next sample runs normally.
- Stray and simultaneous events:
  - fir_done_in pulsed while in LP → ignored.
  - Done asserted in the same cycle the watchdog limit is hit → normal advance, no timeout.
- Reset mid-frame: assert rst_in = 0 during ERR.
  - All outputs 0 immediately; after release, no start pulse until sample_valid_in.
